// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control slice.
// Contents: state encodings, opcode/funct constants, ALU control codes,
// ALUSrcB/PCSource select codes, the packed control-word struct produced
// by the output decoder, and an opcode-support helper used in DECODE.
package mips_ctrl_pkg;

  // Number of bits that carry a meaningful state code; STATE_W may be wider.
  localparam int STATE_CODE_W = 4;

  typedef enum logic [STATE_CODE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JEX    = 4'd11
  } ctrl_state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALUControl codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One full set of datapath controls for a single cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_write;
    logic       mem_read;
    logic       alu_src_a;
    logic       reg_write;
    logic       retire;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_control;
  } ctrl_word_t;

  // True for every opcode this control unit knows how to sequence.
  function automatic logic op_supported(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type Funct decoder.
// Ports:
//   funct       in  6  instruction[5:0]
//   alu_control out 3  ALU operation for the supported functs (add otherwise)
//   funct_valid out 1  funct is one of add/sub/and/or/slt
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_control,
  output logic       funct_valid
);

  always_comb begin
    alu_control = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS core with a memory-ready handshake.
// Ports:
//   clk, reset (async, active-low)
//   Opcode, Funct        instruction fields from the datapath IR
//   MemReady             memory completes the current read/write this cycle
//   PCWrite .. Illegal   datapath strobes and selects (Moore, plus MemReady
//                        gating in FETCH and MEMWR)
//   State                current state register, for debug
// Handshake: a memory access is presented (MemRead or MemWrite high, with
// IorD/address stable) every cycle until a cycle in which MemReady=1; that
// cycle completes the access and the FSM advances on the following edge.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               MemWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [2:0]         ALUControl,
  output logic               MemRead,
  output logic               Retire,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0]      state_q, state_d;
  // Remembers sw vs lw from DECODE so MEMADR needs no second IR sample.
  logic                    is_store_q, is_store_d;
  logic [STATE_CODE_W-1:0] cur_code;
  logic                    state_in_range;
  ctrl_state_e             next_code;
  logic [2:0]              fn_alu_control;
  logic                    fn_valid;
  logic                    decode_illegal;
  ctrl_word_t              cw;

  mips_alu_decoder u_alu_dec (
    .funct       (Funct),
    .alu_control (fn_alu_control),
    .funct_valid (fn_valid)
  );

  // Codes above JEX (including any set upper bit when STATE_W > 4) are
  // folded onto 4'hF, which hits the default arms below.
  assign state_in_range = (state_q <= STATE_W'(S_JEX));
  assign cur_code       = state_in_range ? state_q[STATE_CODE_W-1:0] : 4'hF;

  assign decode_illegal = !op_supported(Opcode) ||
                          ((Opcode == OP_RTYPE) && !fn_valid);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    next_code  = S_FETCH;
    is_store_d = is_store_q;
    case (cur_code)
      S_FETCH:  next_code = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        is_store_d = (Opcode == OP_SW);
        if (decode_illegal) begin
          next_code = S_FETCH;
        end else begin
          case (Opcode)
            OP_LW, OP_SW: next_code = S_MEMADR;
            OP_RTYPE:     next_code = S_RTEX;
            OP_BEQ:       next_code = S_BEQEX;
            OP_ADDI:      next_code = S_ADDIEX;
            OP_J:         next_code = S_JEX;
            default:      next_code = S_FETCH;
          endcase
        end
      end
      S_MEMADR: next_code = is_store_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  next_code = MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_code = S_FETCH;
      S_MEMWR:  next_code = MemReady ? S_FETCH : S_MEMWR;
      S_RTEX:   next_code = S_RTWB;
      S_RTWB:   next_code = S_FETCH;
      S_BEQEX:  next_code = S_FETCH;
      S_ADDIEX: next_code = S_ADDIWB;
      S_ADDIWB: next_code = S_FETCH;
      S_JEX:    next_code = S_FETCH;
      default:  next_code = S_FETCH;
    endcase
    state_d = STATE_W'(next_code);
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    cw = '0;
    case (cur_code)
      S_FETCH: begin
        cw.mem_read    = 1'b1;
        cw.alu_src_b   = SRCB_FOUR;
        cw.alu_control = ALU_ADD;
        cw.pc_source   = PCSRC_ALU;
        cw.ir_write    = MemReady;
        cw.pc_write    = MemReady;
      end
      S_DECODE: begin
        cw.alu_src_b   = SRCB_IMM_SH;
        cw.alu_control = ALU_ADD;
      end
      S_MEMADR: begin
        cw.alu_src_a   = 1'b1;
        cw.alu_src_b   = SRCB_IMM;
        cw.alu_control = ALU_ADD;
      end
      S_MEMRD: begin
        cw.mem_read = 1'b1;
        cw.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        cw.retire     = 1'b1;
      end
      S_MEMWR: begin
        cw.i_or_d    = 1'b1;
        cw.mem_write = 1'b1;
        cw.retire    = MemReady;
      end
      S_RTEX: begin
        cw.alu_src_a   = 1'b1;
        cw.alu_src_b   = SRCB_B;
        cw.alu_control = fn_alu_control;
      end
      S_RTWB: begin
        cw.reg_dst   = 1'b1;
        cw.reg_write = 1'b1;
        cw.retire    = 1'b1;
      end
      S_BEQEX: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = SRCB_B;
        cw.alu_control   = ALU_SUB;
        cw.pc_source     = PCSRC_ALUOUT;
        cw.pc_write_cond = 1'b1;
        cw.retire        = 1'b1;
      end
      S_ADDIEX: begin
        cw.alu_src_a   = 1'b1;
        cw.alu_src_b   = SRCB_IMM;
        cw.alu_control = ALU_ADD;
      end
      S_ADDIWB: begin
        cw.reg_write = 1'b1;
        cw.retire    = 1'b1;
      end
      S_JEX: begin
        cw.pc_source = PCSRC_JUMP;
        cw.pc_write  = 1'b1;
        cw.retire    = 1'b1;
      end
      default: cw = '0;
    endcase
  end

  // Strobes are gated by reset directly so they fall in the same cycle the
  // reset is asserted, not at the next clock edge. Selects need no gating:
  // the async state clear already puts them at their FETCH values.
  assign PCWrite     = cw.pc_write      & reset;
  assign PCWriteCond = cw.pc_write_cond & reset;
  assign IRWrite     = cw.ir_write      & reset;
  assign MemWrite    = cw.mem_write     & reset;
  assign RegWrite    = cw.reg_write     & reset;
  assign MemRead     = cw.mem_read      & reset;
  assign Retire      = cw.retire        & reset;
  assign Illegal     = (cur_code == S_DECODE) & decode_illegal & reset;

  assign IorD       = cw.i_or_d;
  assign RegDst     = cw.reg_dst;
  assign MemToReg   = cw.mem_to_reg;
  assign ALUSrcA    = cw.alu_src_a;
  assign ALUSrcB    = cw.alu_src_b;
  assign PCSource   = cw.pc_source;
  assign ALUControl = cw.alu_control;

  assign State = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed testbench for mips_multicycle_control.
// strobes = {PCWrite,PCWriteCond,IRWrite,MemWrite,RegWrite,MemRead,Retire,Illegal}
// sels    = {IorD,RegDst,MemToReg,ALUSrcA,ALUSrcB,PCSource,ALUControl}
module tb_mips_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, IRWrite, RegDst, MemToReg;
  logic       MemWrite, ALUSrcA, RegWrite, MemRead, Retire, Illegal;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUControl;
  logic [3:0] State;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  strobes;
  logic [10:0] sels;
  assign strobes = {PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, MemRead, Retire, Illegal};
  assign sels    = {IorD, RegDst, MemToReg, ALUSrcA, ALUSrcB, PCSource, ALUControl};

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .RegDst      (RegDst),
    .MemToReg    (MemToReg),
    .MemWrite    (MemWrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .ALUControl  (ALUControl),
    .MemRead     (MemRead),
    .Retire      (Retire),
    .Illegal     (Illegal),
    .State       (State)
  );

  // ------------------------------------------------------------ clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after a rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [3:0] exp_st [0:5];
    logic [7:0] exp_sb [0:5];
    int ret_cnt;
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    exp_sb = '{8'b1010_0100, 8'b0, 8'b0, 8'b0000_0100, 8'b0000_1010, 8'b1010_0100};
    reset = 1'b0; MemReady = 1'b1; Opcode = 6'b100011; Funct = 6'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      checks++; if (State !== 4'd0) begin failures++; $display("FAIL reset_state[%0d]: got %0d expected 0", i, State); end
      checks++; if (strobes !== 8'b0) begin failures++; $display("FAIL reset_strobes[%0d]: got %b expected 00000000", i, strobes); end
    end
    checks++; if (sels !== 11'b0_0_0_0_01_00_010) begin failures++; $display("FAIL reset_sels: got %b expected 00000100010", sels); end
    reset = 1'b1;
    ret_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      #1;
      checks++; if (State !== exp_st[i]) begin failures++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, State, exp_st[i]); end
      checks++; if (strobes !== exp_sb[i]) begin failures++; $display("FAIL lw_strobes[%0d]: got %b expected %b", i, strobes, exp_sb[i]); end
      checks++; if (MemToReg !== (exp_st[i] == 4'd4)) begin failures++; $display("FAIL lw_memtoreg[%0d]: got %b", i, MemToReg); end
      if (Retire === 1'b1) ret_cnt++;
      if (i == 2) begin
        checks++; if (sels !== 11'b0_0_0_1_10_00_010) begin failures++; $display("FAIL memadr_sels: got %b expected 00011000010", sels); end
      end
      if (i == 3) begin
        checks++; if (sels !== 11'b1_0_0_0_00_00_000) begin failures++; $display("FAIL memrd_sels: got %b expected 10000000000", sels); end
      end
    end
    checks++; if (ret_cnt !== 1) begin failures++; $display("FAIL lw_retire_count: got %0d expected 1", ret_cnt); end
  endtask

  task automatic test_lw_stall();
    Opcode = 6'b100011; MemReady = 1'b0; #1;
    checks++; if (strobes !== 8'b0000_0100) begin failures++; $display("FAIL fetch_stall_strobes: got %b expected 00000100", strobes); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL fetch_stall_state: got %0d expected 0", State); end
    MemReady = 1'b1; #1;
    checks++; if (strobes !== 8'b1010_0100) begin failures++; $display("FAIL fetch_ready_strobes: got %b expected 10100100", strobes); end
    tick(); tick(); tick();
    MemReady = 1'b0; #1;
    checks++; if (State !== 4'd3) begin failures++; $display("FAIL memrd_reach: got %0d expected 3", State); end
    tick(); #1;
    checks++; if (State !== 4'd3 || strobes !== 8'b0000_0100) begin failures++; $display("FAIL memrd_hold: got state %0d strobes %b expected 3 00000100", State, strobes); end
    MemReady = 1'b1;
    tick(); #1;
    checks++; if (State !== 4'd4) begin failures++; $display("FAIL memrd_release: got %0d expected 4", State); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL lw_stall_end: got %0d expected 0", State); end
  endtask

  task automatic test_sw_stall();
    int mw_cnt;
    logic rw_seen;
    Opcode = 6'b101011; MemReady = 1'b1; rw_seen = 1'b0; mw_cnt = 0;
    tick(); #1;
    checks++; if (sels !== 11'b0_0_0_0_11_00_010) begin failures++; $display("FAIL decode_sels: got %b expected 00001100010", sels); end
    rw_seen |= RegWrite;
    tick(); #1; rw_seen |= RegWrite;
    tick();
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      if (i == 2) MemReady = 1'b1;
      #1;
      rw_seen |= RegWrite;
      if (MemWrite === 1'b1 && IorD === 1'b1) mw_cnt++;
      checks++; if (State !== 4'd5) begin failures++; $display("FAIL sw_state[%0d]: got %0d expected 5", i, State); end
      checks++; if (Retire !== (i == 2)) begin failures++; $display("FAIL sw_retire[%0d]: got %b", i, Retire); end
    end
    checks++; if (strobes !== 8'b0001_0010) begin failures++; $display("FAIL sw_accept_strobes: got %b expected 00010010", strobes); end
    checks++; if (mw_cnt !== 3) begin failures++; $display("FAIL sw_memwrite_cycles: got %0d expected 3", mw_cnt); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL sw_end: got %0d expected 0", State); end
    checks++; if (rw_seen !== 1'b0) begin failures++; $display("FAIL sw_no_regwrite: got %b expected 0", rw_seen); end
  endtask

  task automatic test_rtype();
    Opcode = 6'b000000; Funct = 6'b100010; MemReady = 1'b1;
    tick(); #1;
    checks++; if (State !== 4'd1 || Illegal !== 1'b0) begin failures++; $display("FAIL r_decode: got state %0d illegal %b expected 1 0", State, Illegal); end
    tick(); #1;
    checks++; if (State !== 4'd6) begin failures++; $display("FAIL r_ex_state: got %0d expected 6", State); end
    checks++; if (sels !== 11'b0_0_0_1_00_00_110) begin failures++; $display("FAIL r_ex_sels: got %b expected 00010000110", sels); end
    tick(); #1;
    checks++; if (RegDst !== 1'b1 || strobes !== 8'b0000_1010) begin failures++; $display("FAIL r_wb: got regdst %b strobes %b expected 1 00001010", RegDst, strobes); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL r_end: got %0d expected 0", State); end
    // slt through the same path
    Funct = 6'b101010;
    tick(); tick(); #1;
    checks++; if (ALUControl !== 3'b111) begin failures++; $display("FAIL r_slt_alu: got %b expected 111", ALUControl); end
    tick(); tick(); #1;
  endtask

  task automatic test_beq_addi();
    Opcode = 6'b000100; MemReady = 1'b1;
    tick(); tick(); #1;
    checks++; if (State !== 4'd8) begin failures++; $display("FAIL beq_state: got %0d expected 8", State); end
    checks++; if (strobes !== 8'b0100_0010) begin failures++; $display("FAIL beq_strobes: got %b expected 01000010", strobes); end
    checks++; if (sels !== 11'b0_0_0_1_00_01_110) begin failures++; $display("FAIL beq_sels: got %b expected 00010001110", sels); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL beq_end: got %0d expected 0", State); end
    Opcode = 6'b001000;
    tick(); tick(); #1;
    checks++; if (State !== 4'd9 || sels !== 11'b0_0_0_1_10_00_010) begin failures++; $display("FAIL addi_ex: got state %0d sels %b expected 9 00011000010", State, sels); end
    tick(); #1;
    checks++; if (State !== 4'd10 || strobes !== 8'b0000_1010 || sels !== 11'b0) begin failures++; $display("FAIL addi_wb: got state %0d strobes %b sels %b", State, strobes, sels); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL addi_end: got %0d expected 0", State); end
  endtask

  task automatic test_illegal_jump();
    Opcode = 6'b111111; MemReady = 1'b1;
    tick(); #1;
    checks++; if (State !== 4'd1 || strobes !== 8'b0000_0001) begin failures++; $display("FAIL illegal_op: got state %0d strobes %b expected 1 00000001", State, strobes); end
    tick(); #1;
    checks++; if (State !== 4'd0 || Illegal !== 1'b0) begin failures++; $display("FAIL illegal_op_next: got state %0d illegal %b expected 0 0", State, Illegal); end
    Opcode = 6'b000000; Funct = 6'b000111;
    tick(); #1;
    checks++; if (strobes !== 8'b0000_0001) begin failures++; $display("FAIL illegal_funct: got %b expected 00000001", strobes); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL illegal_funct_next: got %0d expected 0", State); end
    Opcode = 6'b000010; Funct = 6'b0;
    tick(); tick(); #1;
    checks++; if (State !== 4'd11 || strobes !== 8'b1000_0010) begin failures++; $display("FAIL j_ex: got state %0d strobes %b expected 11 10000010", State, strobes); end
    checks++; if (PCSource !== 2'b10) begin failures++; $display("FAIL j_pcsource: got %b expected 10", PCSource); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL j_end: got %0d expected 0", State); end
  endtask

  task automatic test_reset_mid();
    Opcode = 6'b101011; MemReady = 1'b1;
    tick(); tick(); tick();
    MemReady = 1'b0; #1;
    checks++; if (State !== 4'd5 || strobes !== 8'b0001_0000) begin failures++; $display("FAIL mid_memwr: got state %0d strobes %b expected 5 00010000", State, strobes); end
    reset = 1'b0; #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL mid_reset_state: got %0d expected 0", State); end
    checks++; if (strobes !== 8'b0) begin failures++; $display("FAIL mid_reset_strobes: got %b expected 00000000", strobes); end
    checks++; if (sels !== 11'b0_0_0_0_01_00_010) begin failures++; $display("FAIL mid_reset_sels: got %b expected 00000100010", sels); end
    tick();
    reset = 1'b1; #1;
    checks++; if (State !== 4'd0 || strobes !== 8'b0000_0100) begin failures++; $display("FAIL post_reset_stall: got state %0d strobes %b expected 0 00000100", State, strobes); end
    tick(); #1;
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL post_reset_hold: got %0d expected 0", State); end
    MemReady = 1'b1; #1;
    checks++; if (strobes !== 8'b1010_0100) begin failures++; $display("FAIL post_reset_fetch: got %b expected 10100100", strobes); end
    tick(); #1;
    checks++; if (State !== 4'd1) begin failures++; $display("FAIL post_reset_decode: got %0d expected 1", State); end
  endtask

  // ------------------------------------------------------------- sequence
  initial begin
    reset = 1'b0; MemReady = 1'b0; Opcode = 6'b0; Funct = 6'b0;
    test_reset();
    test_lw_stall();
    test_sw_stall();
    test_rtype();
    test_beq_addi();
    test_illegal_jump();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS core. It sits directly upstream of the multicycle datapath.
- Consumes Opcode/Funct from the datapath instruction register. Produces every datapath control strobe and mux select each cycle.
- Adds a memory-ready handshake so fetch and data accesses can stall on slow memory.

Parameters:
- STATE_W, 4, width of state register; must be >= 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- Opcode  in  6  instruction[31:26] from datapath.
- Funct  in  6  instruction[5:0] from datapath.
- MemReady  in  1  memory completes current read/write this cycle.
- PCWrite, PCWriteCond, IorD, IRWrite, RegDst, MemToReg, MemWrite, ALUSrcA, RegWrite  out  1 each  datapath controls.
- ALUSrcB  out  2  00=B reg, 01=4, 10=signext imm, 11=signext imm<<2.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- MemRead  out  1  memory read request.
- Retire  out  1  one-cycle pulse on final cycle of each completed instruction.
- Illegal  out  1  one-cycle pulse in DECODE for unsupported opcode/funct.
- State  out  STATE_W  current state, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 are unreachable and go to FETCH.
- While reset=0: state=FETCH. All write and request strobes (PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite, MemRead, Retire, Illegal) are forced to 0. Selects take their FETCH values. State=0.
- Outputs are Moore-decoded from state, except where MemReady gating applies. Any field not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSource=00. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0, otherwise goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, add (branch target into ALUOut). Next state by opcode:
  - 100011 lw / 101011 sw -> MEMADR
  - 000000 R -> RTEX
  - 000100 beq -> BEQEX
  - 001000 addi -> ADDIEX
  - 000010 j -> JEX
  - other opcode -> FETCH with Illegal=1
  - R-type with Funct not in {100000, 100010, 100100, 100101, 101010} -> FETCH with Illegal=1
- MEMADR: ALUSrcA=1, ALUSrcB=10, add. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then MEMWB.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, Retire=1, then FETCH.
- MEMWR: IorD=1, MemWrite=1 (held every cycle until accepted). On MemReady=1: Retire=1, then FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct (add 010, sub 110, and 000, or 001, slt 111), then RTWB.
- RTWB: RegDst=1, MemToReg=0, RegWrite=1, Retire=1, then FETCH.
- BEQEX: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSource=01, PCWriteCond=1, Retire=1, then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, add, then ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1, Retire=1, then FETCH.
- JEX: PCSource=10, PCWrite=1, Retire=1, then FETCH.
- Latency with MemReady tied to 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3 cycles. Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset asserted mid-instruction: immediate return to FETCH. No partial RegWrite/MemWrite may be issued in the reset cycle. After release, execution resumes with a fetch.
- Opcode/Funct are sampled only in DECODE and RTEX. The IR is stable there because IRWrite=0 outside FETCH.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encodings
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALUControl codes and ALUSrcB/PCSource select codes
- One sub-module: mips_alu_decoder, a combinational Funct -> {ALUControl, funct_valid} decoder. RTEX and DECODE both use it.

Test Plan:
- Hold reset=0 for 3 cycles, release with Opcode=100011, MemReady=1 -> State sequence 0,1,2,3,4,0. RegWrite=1 and MemToReg=1 only in state 4. Retire pulses once.
- sw with MemReady low for 2 cycles in MEMWR -> MemWrite=1 and IorD=1 for 3 consecutive cycles. Retire on the third. No RegWrite at any point.
- R-type with Funct=100010 -> ALUControl=110 in RTEX. RTWB shows RegDst=1, RegWrite=1. Total 4 cycles.
- beq (000100) -> BEQEX shows PCWriteCond=1, PCSource=01, ALUControl=110, PCWrite=0. Returns to FETCH after 3 cycles.
- Opcode=111111 in DECODE -> Illegal=1 for exactly one cycle, next state FETCH, no write strobes asserted. Then j (000010): JEX shows PCWrite=1, PCSource=10.
- Pull reset low during MEMWR with MemWrite=1 -> MemWrite drops asynchronously in the same cycle. State=0. After release, FETCH with IRWrite gated by MemReady.
